// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Optional fetch counter is enabled by defining IFETCH_CNT_EN.
package ifetch_pkg;

   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W      = 4;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic in_range(input logic [31:0] addr, input int depth);
      return (addr < $unsigned(depth));
   endfunction

endpackage

// File: rtl/ifetch_mem.sv
// Program storage: one write port, one asynchronous read port.
// Addresses at or beyond DEPTH drop writes and read back NOP_INST.
module ifetch_mem
   import ifetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 64
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [IDX_W-1:0]  w_widx;
   logic [IDX_W-1:0]  w_ridx;
   logic              w_wr_ok;
   logic              w_rd_ok;

   assign w_widx  = i_waddr[IDX_W-1:0];
   assign w_ridx  = i_raddr[IDX_W-1:0];
   assign w_wr_ok = in_range(32'(i_waddr), DEPTH);
   assign w_rd_ok = in_range(32'(i_raddr), DEPTH);

   // Array is intentionally not reset so a loaded program survives a CPU reset.
   always_ff @(posedge clk) begin
      if (i_we && w_wr_ok) begin
         r_mem[w_widx] <= i_wdata;
      end
   end

   assign o_rdata = w_rd_ok ? r_mem[w_ridx] : DATA_W'(NOP_INST);

endmodule

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: request FSM with programmable wait states.
// Define IFETCH_CNT_EN to add the saturating fetch_cnt output and cnt_clr input.
module ifetch_responder
   import ifetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = 64,
   parameter int WAIT_CYC = 2
) (
   input  logic              clk,
   input  logic              Rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] Inst_Addr,
   output logic [DATA_W-1:0] Inst,
   output logic              Inst_Valid,
   output logic              busy,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
`ifdef IFETCH_CNT_EN
   ,
   input  logic              cnt_clr,
   output logic [15:0]       fetch_cnt
`endif
);

   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : {CNT_W{1'b0}};

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic [CNT_W-1:0]  w_wait_nxt;
   logic [ADDR_W-1:0] r_addr_q;
   logic [DATA_W-1:0] r_inst;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] w_resp_data;
   logic              w_accept;
   logic              w_fwd;

   ifetch_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (ld_we),
      .i_waddr (ld_addr),
      .i_wdata (ld_data),
      .i_raddr (r_addr_q),
      .o_rdata (w_rd_data)
   );

   assign w_accept = (r_state == IDLE) && req;

   // Next-state and wait-counter logic.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      case (r_state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYC > 0) begin
                  w_state_nxt = WAIT;
                  w_wait_nxt  = WAIT_LOAD;
               end else begin
                  w_state_nxt = RESP;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WAIT: begin
            if (r_wait_cnt == {CNT_W{1'b0}}) begin
               w_state_nxt = RESP;
            end else begin
               w_wait_nxt = r_wait_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Write-first: a loader write hitting the address being returned wins over the stored word.
   assign w_fwd       = ld_we && (ld_addr == r_addr_q) && in_range(32'(ld_addr), DEPTH);
   assign w_resp_data = w_fwd ? ld_data : w_rd_data;

   // FSM state, captured address, wait counter and held instruction.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state    <= IDLE;
         r_wait_cnt <= {CNT_W{1'b0}};
         r_addr_q   <= {ADDR_W{1'b0}};
         r_inst     <= {DATA_W{1'b0}};
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_accept) begin
            r_addr_q <= Inst_Addr;
         end
         if (r_state == RESP) begin
            r_inst <= w_resp_data;
         end
      end
   end

   assign Inst_Valid = (r_state == RESP);
   assign busy       = (r_state != IDLE);
   assign Inst       = Inst_Valid ? w_resp_data : r_inst;

`ifdef IFETCH_CNT_EN
   logic [15:0] r_fetch_cnt;

   // Saturating response counter; clear has priority over increment.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_fetch_cnt <= 16'h0000;
      end else if (cnt_clr) begin
         r_fetch_cnt <= 16'h0000;
      end else if (Inst_Valid && (r_fetch_cnt != 16'hFFFF)) begin
         r_fetch_cnt <= r_fetch_cnt + 16'h0001;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench: dut0 (DEPTH=32, WAIT_CYC=2) and dut1 (DEPTH=64, WAIT_CYC=0)
// share the loader port; a word-array model predicts every response.
module tb_ifetch_responder;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req;
   logic [1:0][5:0]  addr;
   logic [1:0][31:0] inst;
   logic [1:0]       vld;
   logic [1:0]       bsy;
   logic             ld_we;
   logic [5:0]       ld_addr;
   logic [31:0]      ld_data;
`ifdef IFETCH_CNT_EN
   logic             cnt_clr;
   logic [1:0][15:0] fcnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [2][64];
   int depth_m [2] = '{32, 64};
   int wcyc_m  [2] = '{2, 0};
   int cnt_m   [2] = '{0, 0};

   always #5 clk = ~clk;

   ifetch_responder #(.ADDR_W(6), .DATA_W(32), .DEPTH(32), .WAIT_CYC(2)) dut0 (
      .clk(clk), .Rst(rst_n), .req(req[0]), .Inst_Addr(addr[0]), .Inst(inst[0]),
      .Inst_Valid(vld[0]), .busy(bsy[0]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IFETCH_CNT_EN
      , .cnt_clr(cnt_clr), .fetch_cnt(fcnt[0])
`endif
   );

   ifetch_responder #(.ADDR_W(6), .DATA_W(32), .DEPTH(64), .WAIT_CYC(0)) dut1 (
      .clk(clk), .Rst(rst_n), .req(req[1]), .Inst_Addr(addr[1]), .Inst(inst[1]),
      .Inst_Valid(vld[1]), .busy(bsy[1]), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IFETCH_CNT_EN
      , .cnt_clr(cnt_clr), .fetch_cnt(fcnt[1])
`endif
   );

   typedef struct {
      int          d;
      int          a;
      logic [31:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mread(input int d, input int a);
      return (a < depth_m[d]) ? mem_m[d][a] : 32'h0000_0000;
   endfunction

   function automatic void mwrite(input int a, input logic [31:0] v);
      for (int d = 0; d < 2; d++) begin
         if (a < depth_m[d]) mem_m[d][a] = v;
      end
   endfunction

   // Called at a negedge; leaves the bench at the following negedge.
   task automatic load(input int a, input logic [31:0] v);
      ld_we = 1'b1; ld_addr = 6'(a); ld_data = v;
      @(negedge clk);
      ld_we = 1'b0;
      mwrite(a, v);
   endtask

   // Called at the first negedge after the accepting edge; ends at the negedge after RESP.
   task automatic wait_resp(input int d, input int a, input bit fwd, input logic [31:0] fd);
      int lat = 0;
      int nb = 0;
      logic [31:0] e;
      for (int c = 1; c <= 20; c++) begin
         if (bsy[d]) nb++;
         if (vld[d]) begin
            lat = c;
            break;
         end
         @(negedge clk);
      end
      chk($sformatf("latency d%0d a%0d", d, a), 32'(lat), 32'(wcyc_m[d] + 1));
      chk($sformatf("busy_cycles d%0d", d), 32'(nb), 32'(wcyc_m[d] + 1));
      e = mread(d, a);
      if (fwd) begin
         ld_we = 1'b1; ld_addr = 6'(a); ld_data = fd;
         #1;
         if (a < depth_m[d]) e = fd;
         mwrite(a, fd);
      end
      chk($sformatf("inst d%0d a%0d", d, a), inst[d], e);
      if (lat != 0) cnt_m[d]++;
      @(negedge clk);
      ld_we = 1'b0;
      chk($sformatf("valid_pulse d%0d", d), 32'(vld[d]), 32'd0);
      chk($sformatf("inst_hold d%0d", d), inst[d], e);
   endtask

   task automatic fetch(input int d, input int a, input bit fwd, input logic [31:0] fd);
      chk($sformatf("idle_before d%0d", d), 32'(bsy[d]), 32'd0);
      req[d] = 1'b1; addr[d] = 6'(a);
      @(negedge clk);
      req[d] = 1'b0;
      wait_resp(d, a, fwd, fd);
   endtask

   initial begin
      vec_t tbl [7];
      tbl[0] = '{0, 0,  32'hE3A0_0001};
      tbl[1] = '{0, 3,  32'hEAFF_FFFD};
      tbl[2] = '{0, 40, 32'h0000_0000};
      tbl[3] = '{0, 8,  32'hA5A5_0008};
      tbl[4] = '{1, 2,  32'hE080_2001};
      tbl[5] = '{1, 3,  32'hEAFF_FFFD};
      tbl[6] = '{1, 1,  32'hE3A0_1002};

      rst_n = 1'b0; req = 2'b00; addr = '0; ld_we = 1'b0; ld_addr = 6'd0; ld_data = 32'd0;
`ifdef IFETCH_CNT_EN
      cnt_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_inst", inst[d], 32'd0);
         chk("reset_valid", 32'(vld[d]), 32'd0);
         chk("reset_busy", 32'(bsy[d]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 64; i++) load(i, $urandom);
      load(0, 32'hE3A0_0001);
      load(1, 32'hE3A0_1002);
      load(2, 32'hE080_2001);
      load(3, 32'hEAFF_FFFD);
      load(8, 32'hA5A5_0008);

      for (int i = 0; i < 7; i++) begin
         fetch(tbl[i].d, tbl[i].a, 1'b0, 32'd0);
         chk($sformatf("table_%0d", i), inst[tbl[i].d], tbl[i].exp);
      end

      // Out-of-range loader write must not alias onto mem[8] of the 32-word array.
      load(40, 32'hDEAD_BEEF);
      fetch(0, 8, 1'b0, 32'd0);
      chk("oor_write_alias", inst[0], 32'hA5A5_0008);
      fetch(0, 40, 1'b0, 32'd0);
      chk("oor_read_nop", inst[0], 32'h0000_0000);

      // req held through the busy period with the address changing mid-fetch.
      req[0] = 1'b1; addr[0] = 6'd1;
      @(negedge clk);
      addr[0] = 6'd3;
      wait_resp(0, 1, 1'b0, 32'd0);
      chk("held_first", inst[0], 32'hE3A0_1002);
      chk("held_idle", 32'(bsy[0]), 32'd0);
      @(negedge clk);
      req[0] = 1'b0;
      wait_resp(0, 3, 1'b0, 32'd0);
      chk("held_second", inst[0], 32'hEAFF_FFFD);

      fetch(0, 1, 1'b1, 32'h1234_5678);
      chk("fwd_inst", inst[0], 32'h1234_5678);
      fetch(0, 1, 1'b0, 32'd0);
      chk("fwd_refetch", inst[0], 32'h1234_5678);

      for (int i = 0; i < 40; i++) begin
         int d;
         int a;
         d = int'($urandom_range(0, 1));
         a = int'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, 63)), $urandom);
         if ($urandom_range(0, 2) == 0) @(negedge clk);
         fetch(d, a, ($urandom_range(0, 3) == 0), $urandom);
      end
`ifdef IFETCH_CNT_EN
      chk("cnt_run d0", 32'(fcnt[0]), 32'(cnt_m[0]));
      chk("cnt_run d1", 32'(fcnt[1]), 32'(cnt_m[1]));
`endif

      // Reset while dut0 is waiting aborts the fetch.
      req[0] = 1'b1; addr[0] = 6'd0;
      @(negedge clk);
      req[0] = 1'b0;
      chk("abort_busy_pre", 32'(bsy[0]), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_inst", inst[0], 32'd0);
      chk("abort_busy", 32'(bsy[0]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_novalid", 32'(vld[0]), 32'd0);
      end
      rst_n = 1'b1;
      cnt_m[0] = 0; cnt_m[1] = 0;
      fetch(0, 0, 1'b0, 32'd0);
      chk("after_reset", inst[0], 32'hE3A0_0001);
`ifdef IFETCH_CNT_EN
      chk("cnt_after_reset", 32'(fcnt[0]), 32'd1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      chk("cnt_clr d0", 32'(fcnt[0]), 32'd0);
      chk("cnt_clr d1", 32'(fcnt[1]), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
- Responder end of the CPU instruction-fetch interface.
- Accepts a fetch request plus word address (Inst_Addr) from the multi-cycle CPU and returns Inst after a programmable wait-state count, flagged by a one-cycle Inst_Valid pulse.
- Holds the program in an internal word array, loaded through a side write port by the test harness or boot loader.
- Sits between top_CPU's fetch stage (Write_IR gating) and program storage.

Parameters:
- ADDR_W, 6, word-address width (matches Inst_Addr).
- DATA_W, 32, instruction width.
- DEPTH, 64, number of stored words; DEPTH <= 2**ADDR_W.
- WAIT_CYC, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req  in  1  fetch request, sampled only in IDLE.
- Inst_Addr  in  ADDR_W  fetch word address, captured with req.
- Inst  out  DATA_W  fetched instruction, held until the next response.
- Inst_Valid  out  1  one-cycle pulse: Inst updated this cycle.
- busy  out  1  high while a fetch is in flight (state != IDLE).
- ld_we  in  1  loader write enable.
- ld_addr  in  ADDR_W  loader word address.
- ld_data  in  DATA_W  loader write data.

Behaviour:
- Reset (Rst low, asynchronous):
  - State goes to IDLE; Inst=0, Inst_Valid=0, busy=0, wait counter=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 captures Inst_Addr into addr_q.
  - If WAIT_CYC>0: load counter with WAIT_CYC-1 and go to WAIT.
  - Otherwise go to RESP.
  - req=0: stay in IDLE.
- WAIT: counter decrements each cycle; at counter==0 go to RESP.
- RESP:
  - Inst <= mem[addr_q]; Inst_Valid=1 for exactly this cycle; next state IDLE.
- Latency: req sampled at edge N gives Inst_Valid high in cycle N+1+WAIT_CYC.
  - WAIT_CYC=0 gives a 1-cycle response.
- Back-to-back: a req high on the cycle after RESP (back in IDLE) is accepted. Minimum request spacing is WAIT_CYC+2 cycles.
- req while busy is ignored (not queued). The CPU holds its fetch state until Inst_Valid.
- busy is high in WAIT and RESP; it is combinational from state.
- Out of range: addr_q >= DEPTH returns 32'h0000_0000 (ANDEQ r0,r0,r0, an effective NOP).
- Loader writes:
  - Accepted in any state: mem[ld_addr] <= ld_data on the clock edge.
  - ld_addr >= DEPTH is dropped.
- Write/read collision: ld_we with ld_addr==addr_q in the RESP cycle forwards ld_data to Inst (write-first).
- Reset mid-fetch (WAIT or RESP): the fetch is aborted, no Inst_Valid is produced, and Inst returns to 0.

Optional Feature:
- Macro: IFETCH_CNT_EN.
- Defined:
  - Adds output fetch_cnt [15:0], reset to 0.
  - Increments on each Inst_Valid and saturates at 16'hFFFF.
  - Adds input cnt_clr [1], which synchronously zeroes fetch_cnt.
  - cnt_clr wins over a simultaneous increment.
- Not defined: neither port exists and no counter logic is present.

Decomposition:
- ifetch_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - default ADDR_W and DATA_W
  - NOP_INST constant 32'h0
  - counter width localparam (4 bits, covering WAIT_CYC up to 15)
- Sub-module ifetch_mem: DEPTH x DATA_W array with one write port, one asynchronous read port, and out-of-range masking on both ports.
- ifetch_responder contains the FSM, addr_q, wait counter, forwarding mux and optional counter.

Test Plan:
- Reset then load: load mem[0..3] = E3A00001, E3A01002, E0802001, EAFFFFFD; req at addr 0 with WAIT_CYC=2 -> Inst_Valid exactly 3 cycles after the accepting edge, Inst=E3A00001, busy high for 3 cycles.
- WAIT_CYC=0 build: req at addr 2 -> Inst=E0802001 on the next cycle with a single-cycle Inst_Valid; a follow-up req at addr 3 in the next IDLE cycle -> Inst=EAFFFFFD.
- req held high through a busy period with addr changed 1->3 mid-fetch -> response returns mem[1]=E3A01002; the next accepted req returns mem[3].
- ld_we to addr_q=1 with data 12345678 during the RESP cycle -> Inst=12345678 (forwarded); a re-fetch of addr 1 also returns 12345678.
- With DEPTH=32, req at addr 40 -> Inst=00000000 and Inst_Valid asserted; ld_we to addr 40 does not alter mem[8].
- Rst pulled low during WAIT -> Inst=0, busy=0, no Inst_Valid; after release a req at addr 0 returns E3A00001. With IFETCH_CNT_EN, fetch_cnt reads 1 after that fetch and 0 after cnt_clr.
